seq_shift_add_mul: RTL and testbench

Parametrised sequential shift-and-add multiplier; the next generation of the team's 8-bit shift-add multiplier. It takes two WIDTH-bit operands, retires one multiplier bit per clock and returns a 2·WIDTH-bit product with a done flag. It adds runtime signed/unsigned mode, a busy flag and optional early termination. It sits beside the datapath as a multi-cycle arithmetic unit driven by a run/done handshake.

---
 rtl/seq_shift_add_mul.sv | 115 +++++++++++
 tb/tb_seq_shift_add_mul.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, signed/unsigned at runtime.
// Optional early exit when the remaining multiplier is zero: define SEQ_MUL_EARLY_TERM_EN.
module seq_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] ans,
    output logic               done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   ans_q, ans_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   sum;
    logic                 last_step;

    // In signed mode the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    always_comb begin
        sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MUL_EARLY_TERM_EN
        last_step = (cnt_q == LAST_STEP) || (mplier_q[WIDTH-1:1] == '0);
`else
        last_step = (cnt_q == LAST_STEP);
`endif
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        ans_d    = ans_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    ans_d   = neg_q ? (~sum + (2*WIDTH)'(1)) : sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ans_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            ans_q    <= ans_d;
        end
    end

    assign ans  = ans_q;
    assign done = (state_q == DONE);
    assign busy = (state_q == CALC);

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Randomised and directed bench for seq_shift_add_mul against a product/latency model.
module tb_seq_shift_add_mul;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] ans;
    logic           done;
    logic           busy;

    int passed = 0;
    int total  = 0;
    bit cmp_on = 1'b0;

    seq_shift_add_mul #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .sgn  (sgn),
        .a    (a),
        .b    (b),
        .ans  (ans),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 calculating, 2 done; result and cycle count come from arithmetic.
    int             m_mode = 0;
    int             m_left = 0;
    logic [2*W-1:0] m_ans = '0;
    logic [2*W-1:0] m_pend = '0;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic s);
        longint sx, sy;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(sx * sy);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] y, input logic s);
`ifdef SEQ_MUL_EARLY_TERM_EN
        longint mag;
        int hi;
        mag = s ? longint'($signed(y)) : longint'(y);
        if (mag < 0) mag = -mag;
        hi = -1;
        for (int i = 0; i < W; i++) if (mag[i]) hi = i;
        return (hi < 0) ? 1 : hi + 1;
`else
        return W;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_ans  = '0;
        end else begin
            case (m_mode)
                0: if (run) begin
                    m_pend = ref_prod(a, b, sgn);
                    m_left = ref_lat(b, sgn);
                    m_mode = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ans  = m_pend;
                        m_mode = 2;
                    end
                end
                default: if (!run) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_ans", ans, m_ans);
            chk("cyc_done", done, m_mode == 2);
            chk("cyc_busy", busy, m_mode == 1);
        end
    end

    // Runs one operation with run held until done, then drops run for one cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [2*W-1:0] exp_ans, input int lat_full, input int lat_early,
                         input bit check_hold, input logic [2*W-1:0] hold_val);
        int n;
        @(negedge clk); #1;
        a = x; b = y; sgn = s; run = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (check_hold) chk("ans_hold_calc", ans, hold_val);
        end
        if (!done) chk("done_timeout", 0, 1);
        chk("op_ans", ans, exp_ans);
`ifdef SEQ_MUL_EARLY_TERM_EN
        chk("op_latency", n - 1, lat_early);
`else
        chk("op_latency", n - 1, lat_full);
`endif
        @(negedge clk);
        chk("done_held_run_high", done, 1);
        #1 run = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ans", ans, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        #1 rst = 1'b0;
        cmp_on = 1'b1;

        // Literal expectations computed by hand.
        do_op(8'd5,   8'd6,   1'b0, 16'd30,   8, 3, 1'b0, '0);
        do_op(8'hFF,  8'hFF,  1'b0, 16'hFE01, 8, 8, 1'b0, '0);
        do_op(8'hFF,  8'hFF,  1'b1, 16'h0001, 8, 1, 1'b0, '0);
        do_op(8'hF9,  8'd6,   1'b1, 16'hFFD6, 8, 3, 1'b0, '0);
        do_op(8'h80,  8'h80,  1'b1, 16'h4000, 8, 8, 1'b0, '0);
        do_op(8'h80,  8'h7F,  1'b1, 16'hC080, 8, 7, 1'b0, '0);
        do_op(8'd9,   8'd0,   1'b0, 16'd0,    8, 1, 1'b0, '0);

        // Reset in the middle of a calculation.
        @(negedge clk); #1;
        a = 8'd21; b = 8'd21; sgn = 1'b0; run = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1; run = 1'b0;
        #1;
        chk("midrst_ans", ans, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ans", ans, 0);
        do_op(8'd21,  8'd21,  1'b0, 16'd441,  8, 5, 1'b0, '0);

        // Back to back with one low cycle; ans must hold 44 during the second calculation.
        do_op(8'd2,   8'd22,  1'b0, 16'd44,   8, 5, 1'b0, '0);
        do_op(8'd32,  8'd32,  1'b0, 16'd1024, 8, 6, 1'b1, 16'd44);

        // Random operations with random gaps and operand churn during CALC.
        for (int i = 0; i < 60; i++) begin
            int n;
            @(negedge clk); #1;
            a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            run = 1'b1;
            n = 0;
            while (n < 40 && !done) begin
                @(negedge clk); #1;
                n++;
                a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
            end
            if (!done) chk("rand_timeout", 0, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1 run = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
